// File: rtl/aes_top.sv
// rtl/aes_top.sv - iterative AES-128 encrypt core, one round per clock, on-the-fly key schedule.
// Build option AES_ZEROIZE_EN: blank c_data while busy and clear state/round key after done.
module aes_top (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] data,
  output logic [127:0] c_data,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE, RUN} fsm_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] c_data_q, c_data_d;
  logic         done_q, done_d;

  logic [127:0] sb, sr, mc, rk_next, round_out;
  logic [31:0]  t, n0, n1, n2, n3;

  // Byte i of the block sits at [127-8i -: 8]; column c holds bytes 4c..4c+3.
  always_comb begin
    sb = '0;
    sr = '0;
    mc = '0;
    for (int i = 0; i < 16; i++) begin
      sb[127-8*i -: 8] = sbox(state_q[127-8*i -: 8]);
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
    end
  end

  always_comb begin
    t  = {sbox(rk_q[23:16]), sbox(rk_q[15:8]), sbox(rk_q[7:0]), sbox(rk_q[31:24])}
         ^ {rcon(round_q), 24'h000000};
    n0 = rk_q[127:96] ^ t;
    n1 = rk_q[95:64] ^ n0;
    n2 = rk_q[63:32] ^ n1;
    n3 = rk_q[31:0] ^ n2;
    rk_next   = {n0, n1, n2, n3};
    round_out = ((round_q == 4'd10) ? sr : mc) ^ rk_next;
  end

  always_comb begin
    fsm_d    = fsm_q;
    round_d  = round_q;
    state_d  = state_q;
    rk_d     = rk_q;
    c_data_d = c_data_q;
    done_d   = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start) begin
          state_d = data ^ key;
          rk_d    = key;
          round_d = 4'd1;
          fsm_d   = RUN;
`ifdef AES_ZEROIZE_EN
          c_data_d = '0;
`endif
        end
      end
      RUN: begin
        state_d = round_out;
        rk_d    = rk_next;
        if (round_q == 4'd10) begin
          c_data_d = round_out;
          done_d   = 1'b1;
          round_d  = 4'd0;
          fsm_d    = IDLE;
`ifdef AES_ZEROIZE_EN
          state_d = '0;
          rk_d    = '0;
`endif
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= IDLE;
      round_q  <= 4'd0;
      state_q  <= '0;
      rk_q     <= '0;
      c_data_q <= '0;
      done_q   <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      round_q  <= round_d;
      state_q  <= state_d;
      rk_q     <= rk_d;
      c_data_q <= c_data_d;
      done_q   <= done_d;
    end
  end

  assign c_data = c_data_q;
  assign busy   = (fsm_q == RUN);
  assign done   = done_q;

endmodule

// File: tb/tb_aes_top.sv
// tb/tb_aes_top.sv - scoreboard bench for aes_top using FIPS-197 and zero-key vectors.
module tb_aes_top;

  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CZ = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  typedef struct {
    logic [127:0] ct;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] data = '0;
  logic [127:0] c_data;
  logic         busy;
  logic         done;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  aes_top dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .key    (key),
    .data   (data),
    .c_data (c_data),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("ciphertext", c_data, e.ct);
        check("latency", 128'(cyc), 128'(e.due));
      end
    end
  end

  // Caller aligns to a negedge; inputs are scrambled after the accepting edge.
  task automatic issue(input logic [127:0] k, input logic [127:0] p,
                       input logic [127:0] ct, input bit push);
    key   = k;
    data  = p;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    key   = ~k;
    data  = ~p;
    if (push) sbq.push_back('{ct, cyc + 10});
    check("busy_after_accept", {127'd0, busy}, 128'd1);
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < bound);
    if (done !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", bound);
    end
  endtask

  initial begin
    #3 rst_n = 1'b0;
    #1;
    check("reset_c_data", c_data, 128'd0);
    check("reset_busy", {127'd0, busy}, 128'd0);
    check("reset_done", {127'd0, done}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    issue(KB, PB, CB, 1'b1);
    wait_done(15);
    @(negedge clk);
    issue(KC, PC, CC, 1'b1);
    wait_done(15);
    @(negedge clk);
    issue(128'd0, 128'd0, CZ, 1'b1);
    wait_done(15);

    // Start while busy is ignored; start on the done cycle is accepted.
    @(negedge clk);
    issue(KB, PB, CB, 1'b1);
    repeat (2) @(negedge clk);
    key   = KC;
    data  = PC;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(15);
    issue(KC, PC, CC, 1'b1);
    @(negedge clk);
`ifdef AES_ZEROIZE_EN
    check("c_data_while_busy", c_data, 128'd0);
`else
    check("c_data_while_busy", c_data, CB);
`endif
    wait_done(15);

    // Abort mid-operation with an asynchronous reset.
    @(negedge clk);
    issue(KC, PC, CC, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_c_data", c_data, 128'd0);
    check("abort_busy", {127'd0, busy}, 128'd0);
    check("abort_done", {127'd0, done}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    issue(KC, PC, CC, 1'b1);
    @(negedge clk);
`ifdef AES_ZEROIZE_EN
    check("c_data_while_busy_after_abort", c_data, 128'd0);
`endif
    wait_done(15);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 128'(sbq.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_top.md
Name: aes_top

Overview:
- Iterative AES-128 encryption core (FIPS-197, encrypt only) used as the symmetric cipher in the secure-link datapath.
- Takes a 128-bit key and a 128-bit plaintext block and produces a 128-bit ciphertext block.
- Computes one round per clock and expands the key schedule on the fly.
- Sits between the handshake/key-agreement logic (key source) and the framing logic (consumes c_data).

Parameters:
- none; fixed Nk=4, Nr=10.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to encrypt; accepted only when busy=0.
- key  input  128  cipher key; bits [127:120] = key byte 0.
- data  input  128  plaintext block; bits [127:120] = input byte 0 (FIPS column-major order).
- c_data  output  128  ciphertext, registered; same byte ordering.
- busy  output  1  high while rounds are in progress.
- done  output  1  one-cycle pulse when c_data is updated.

Behaviour:
- Reset (rst_n=0, asynchronous): c_data=0, busy=0, done=0, round counter=0, state and round-key registers=0.
- Accept: at a rising edge with start=1 and busy=0:
  - key and data are sampled.
  - state <= data ^ key (initial AddRoundKey).
  - round key <= key.
  - round counter <= 1.
  - busy <= 1.
- key and data may change after the accepting edge without affecting the operation.
- Rounds 1..9, one per edge while busy: state <= MixColumns(ShiftRows(SubBytes(state))) ^ RK[r].
- RK[r] is derived combinationally from RK[r-1]:
  - w3' = SubWord(RotWord(w3)) ^ Rcon[r].
  - Word chaining: w0 ^= w3'; then w1 ^= new w0; w2 ^= new w1; w3 ^= new w2.
  - Rcon = 01,02,04,08,10,20,40,80,1B,36 in the top byte.
- Round 10: state <= ShiftRows(SubBytes(state)) ^ RK[10], with no MixColumns. On this same edge: c_data <= result, done <= 1, busy <= 0, round counter <= 0.
- Latency: accepting edge E, done=1 and the new c_data are visible after edge E+10. done is high for exactly one cycle.
- Back-to-back operation: start=1 during the done cycle is accepted, since busy=0 then. Throughput is one block per 11 cycles.
- start while busy=1 is ignored; no queuing.
- c_data holds the last result until the next done (see Optional Feature).
- Reset asserted mid-operation aborts the operation immediately to the reset values; no done pulse is produced.
- S-box: one combinational function, instantiated 16 times for the state and 4 times for the key schedule.
- xtime(b) = (b<<1) ^ (b[7] ? 8'h1B : 0).

Optional Feature:
- AES_ZEROIZE_EN
- Defined:
  - On the accepting edge, c_data is cleared to 0, so no stale ciphertext is visible while busy.
  - After done, the internal state and round-key registers are cleared to 0; c_data keeps the result.
- Undefined: c_data holds the previous ciphertext during busy; internal registers keep their last values.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle -> c_data=0, busy=0 and done=0 immediately, without waiting for a clock edge.
- FIPS-197 App. B: key=2b7e151628aed2a6abf7158809cf4f3c, data=3243f6a8885a308d313198a2e0370734, start pulse -> done exactly 10 edges after the accepting edge, c_data=3925841d02dc09fbdc118597196a0b32.
- FIPS-197 App. C.1: key=000102030405060708090a0b0c0d0e0f, data=00112233445566778899aabbccddeeff -> c_data=69c4e0d86a7b0430d8cdb78070b4c55a.
- Zero vector: key=0, data=0 -> c_data=66e94bd4ef8a2c3b884cfa59ca342b2e.
- Start ignored while busy and inputs sampled only at accept: start App. B, then re-assert start with the App. C.1 inputs in cycle 3 -> one done, c_data = App. B result. Then start on the done cycle -> accepted, App. C.1 result 11 cycles later.
- Mid-operation reset: assert rst_n=0 at round 5, release, start App. C.1 -> no done for the aborted operation, then the correct App. C.1 result. With AES_ZEROIZE_EN defined, check c_data=0 during busy.
